// File: rtl/sprite_draw_scheduler_if.sv
// Rectangle-drawer request bus: the scheduler drives the rectangle and the start pulse,
// and the drawer answers with a done pulse.
interface sprite_draw_scheduler_if #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7,
    parameter int unsigned S_W = 5,
    parameter int unsigned C_W = 3
);
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic [S_W-1:0] draw_w;
    logic [S_W-1:0] draw_h;
    logic [C_W-1:0] draw_colour;
    logic           draw_start;
    logic           draw_done;

    modport master (
        output draw_x, draw_y, draw_w, draw_h, draw_colour, draw_start,
        input  draw_done
    );

    modport slave (
        input  draw_x, draw_y, draw_w, draw_h, draw_colour, draw_start,
        output draw_done
    );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite scheduler: snapshots object state, issues one rectangle per live object to
// the drawer and keeps sticky player/bullet vs enemy AABB collision flags.
module sprite_draw_scheduler #(
    parameter int unsigned N_ENEMY = 4,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned S_W     = 5,
    parameter int unsigned C_W     = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_start_i,
    input  logic [X_W-1:0]         player_x_i,
    input  logic [Y_W-1:0]         player_y_i,
    input  logic [S_W-1:0]         player_w_i,
    input  logic [S_W-1:0]         player_h_i,
    input  logic [C_W-1:0]         player_colour_i,
    input  logic [N_ENEMY*X_W-1:0] enemy_x_i,
    input  logic [N_ENEMY*Y_W-1:0] enemy_y_i,
    input  logic [S_W-1:0]         enemy_w_i,
    input  logic [S_W-1:0]         enemy_h_i,
    input  logic [N_ENEMY*C_W-1:0] enemy_colour_i,
    input  logic [N_ENEMY-1:0]     enemy_active_i,
    input  logic [X_W-1:0]         bullet_x_i,
    input  logic [Y_W-1:0]         bullet_y_i,
    input  logic [S_W-1:0]         bullet_w_i,
    input  logic [S_W-1:0]         bullet_h_i,
    input  logic [C_W-1:0]         bullet_colour_i,
    input  logic                   bullet_active_i,
    sprite_draw_scheduler_if.master draw_if,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [N_ENEMY-1:0]     pe_hit_o,
    output logic [N_ENEMY-1:0]     be_hit_o,
    input  logic                   hit_clear_i
);

    localparam int unsigned N_SLOT = N_ENEMY + 2;
    localparam int unsigned SLOT_W = $clog2(N_SLOT);
    localparam int unsigned XE_W   = X_W + 1;
    localparam int unsigned YE_W   = Y_W + 1;

    typedef enum logic [2:0] {StIdle, StEval, StIssue, StWait, StDone} state_e;

    state_e              state_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                busy_q, frame_done_q, draw_start_q;
    logic [X_W-1:0]      draw_x_q;
    logic [Y_W-1:0]      draw_y_q;
    logic [S_W-1:0]      draw_w_q, draw_h_q;
    logic [C_W-1:0]      draw_c_q;
    logic [N_ENEMY-1:0]  pe_hit_q, be_hit_q, pe_hit_d, be_hit_d;

    // Frame snapshot
    logic [X_W-1:0]      snap_px_q, snap_bx_q;
    logic [Y_W-1:0]      snap_py_q, snap_by_q;
    logic [S_W-1:0]      snap_pw_q, snap_ph_q, snap_ew_q, snap_eh_q, snap_bw_q, snap_bh_q;
    logic [C_W-1:0]      snap_pc_q, snap_bc_q;
    logic [X_W-1:0]      snap_ex_q [N_ENEMY];
    logic [Y_W-1:0]      snap_ey_q [N_ENEMY];
    logic [C_W-1:0]      snap_ec_q [N_ENEMY];
    logic [N_ENEMY-1:0]  snap_ea_q;
    logic                snap_ba_q;

    logic [N_ENEMY-1:0]  pe_set, be_set;
    logic [N_SLOT-1:0]   slot_act;
    logic                nxt_found;
    logic [SLOT_W-1:0]   nxt_slot, ld_slot;
    logic [X_W-1:0]      ld_x;
    logic [Y_W-1:0]      ld_y;
    logic [S_W-1:0]      ld_w, ld_h;
    logic [C_W-1:0]      ld_c;

    // Ends are widened by one bit so a sprite near the right/bottom edge never wraps to 0.
    function automatic logic overlap(
        input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
        input logic [S_W-1:0] aw, input logic [S_W-1:0] ah,
        input logic [X_W-1:0] bx, input logic [Y_W-1:0] by,
        input logic [S_W-1:0] bw, input logic [S_W-1:0] bh
    );
        logic [XE_W-1:0] ax_end, bx_end;
        logic [YE_W-1:0] ay_end, by_end;
        logic            nonzero;
        ax_end  = XE_W'(ax) + XE_W'(aw);
        bx_end  = XE_W'(bx) + XE_W'(bw);
        ay_end  = YE_W'(ay) + YE_W'(ah);
        by_end  = YE_W'(by) + YE_W'(bh);
        nonzero = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0);
        return nonzero && (XE_W'(ax) < bx_end) && (XE_W'(bx) < ax_end) &&
               (YE_W'(ay) < by_end) && (YE_W'(by) < ay_end);
    endfunction

    always_comb begin
        pe_set = '0;
        be_set = '0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            pe_set[i] = snap_ea_q[i] && overlap(snap_px_q, snap_py_q, snap_pw_q, snap_ph_q,
                                                snap_ex_q[i], snap_ey_q[i], snap_ew_q, snap_eh_q);
            be_set[i] = snap_ea_q[i] && snap_ba_q &&
                        overlap(snap_bx_q, snap_by_q, snap_bw_q, snap_bh_q,
                                snap_ex_q[i], snap_ey_q[i], snap_ew_q, snap_eh_q);
        end
        // Set beats clear when both land on the same edge.
        pe_hit_d = (pe_hit_q & ~{N_ENEMY{hit_clear_i}}) | ((state_q == StEval) ? pe_set : '0);
        be_hit_d = (be_hit_q & ~{N_ENEMY{hit_clear_i}}) | ((state_q == StEval) ? be_set : '0);
    end

    // Lowest active slot above the current one; slot 0 (player) is always active.
    always_comb begin
        slot_act  = {snap_ba_q, snap_ea_q, 1'b1};
        nxt_found = 1'b0;
        nxt_slot  = '0;
        for (int i = int'(N_SLOT) - 1; i >= 1; i--) begin
            if (slot_act[i] && (SLOT_W'(i) > slot_q)) begin
                nxt_found = 1'b1;
                nxt_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        ld_slot = (state_q == StEval) ? '0 : nxt_slot;
        ld_x    = snap_px_q;
        ld_y    = snap_py_q;
        ld_w    = snap_pw_q;
        ld_h    = snap_ph_q;
        ld_c    = snap_pc_q;
        if (ld_slot == SLOT_W'(N_SLOT - 1)) begin
            ld_x = snap_bx_q;
            ld_y = snap_by_q;
            ld_w = snap_bw_q;
            ld_h = snap_bh_q;
            ld_c = snap_bc_q;
        end
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            if (ld_slot == SLOT_W'(i + 1)) begin
                ld_x = snap_ex_q[i];
                ld_y = snap_ey_q[i];
                ld_w = snap_ew_q;
                ld_h = snap_eh_q;
                ld_c = snap_ec_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            draw_start_q <= 1'b0;
            draw_x_q     <= '0;
            draw_y_q     <= '0;
            draw_w_q     <= '0;
            draw_h_q     <= '0;
            draw_c_q     <= '0;
            pe_hit_q     <= '0;
            be_hit_q     <= '0;
            snap_px_q    <= '0;
            snap_py_q    <= '0;
            snap_pw_q    <= '0;
            snap_ph_q    <= '0;
            snap_pc_q    <= '0;
            snap_ew_q    <= '0;
            snap_eh_q    <= '0;
            snap_ea_q    <= '0;
            snap_bx_q    <= '0;
            snap_by_q    <= '0;
            snap_bw_q    <= '0;
            snap_bh_q    <= '0;
            snap_bc_q    <= '0;
            snap_ba_q    <= 1'b0;
            for (int i = 0; i < int'(N_ENEMY); i++) begin
                snap_ex_q[i] <= '0;
                snap_ey_q[i] <= '0;
                snap_ec_q[i] <= '0;
            end
        end else begin
            draw_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            pe_hit_q     <= pe_hit_d;
            be_hit_q     <= be_hit_d;
            case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (frame_start_i && !busy_q) begin
                        busy_q    <= 1'b1;
                        state_q   <= StEval;
                        snap_px_q <= player_x_i;
                        snap_py_q <= player_y_i;
                        snap_pw_q <= player_w_i;
                        snap_ph_q <= player_h_i;
                        snap_pc_q <= player_colour_i;
                        snap_ew_q <= enemy_w_i;
                        snap_eh_q <= enemy_h_i;
                        snap_ea_q <= enemy_active_i;
                        snap_bx_q <= bullet_x_i;
                        snap_by_q <= bullet_y_i;
                        snap_bw_q <= bullet_w_i;
                        snap_bh_q <= bullet_h_i;
                        snap_bc_q <= bullet_colour_i;
                        snap_ba_q <= bullet_active_i;
                        for (int i = 0; i < int'(N_ENEMY); i++) begin
                            snap_ex_q[i] <= enemy_x_i[i*X_W +: X_W];
                            snap_ey_q[i] <= enemy_y_i[i*Y_W +: Y_W];
                            snap_ec_q[i] <= enemy_colour_i[i*C_W +: C_W];
                        end
                    end
                end
                StEval, StWait: begin
                    if (state_q == StEval || (draw_if.draw_done && nxt_found)) begin
                        slot_q       <= ld_slot;
                        draw_x_q     <= ld_x;
                        draw_y_q     <= ld_y;
                        draw_w_q     <= ld_w;
                        draw_h_q     <= ld_h;
                        draw_c_q     <= ld_c;
                        draw_start_q <= 1'b1;
                        state_q      <= StIssue;
                    end else if (draw_if.draw_done) begin
                        state_q <= StDone;
                    end
                end
                StIssue: state_q <= StWait;
                StDone: begin
                    frame_done_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign draw_if.draw_x      = draw_x_q;
    assign draw_if.draw_y      = draw_y_q;
    assign draw_if.draw_w      = draw_w_q;
    assign draw_if.draw_h      = draw_h_q;
    assign draw_if.draw_colour = draw_c_q;
    assign draw_if.draw_start  = draw_start_q;
    assign busy_o              = busy_q;
    assign frame_done_o        = frame_done_q;
    assign pe_hit_o            = pe_hit_q;
    assign be_hit_o            = be_hit_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: directed and random frames against a list/interval model of
// the draw sequence, pass length and sticky collision flags.
module tb_sprite_draw_scheduler;
    localparam int N = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [2:0] c;
    } rect_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         frame_start = 1'b0;
    logic         hit_clear = 1'b0;
    logic [7:0]   px, bx;
    logic [6:0]   py, by;
    logic [4:0]   pw, ph, ew, eh, bw, bh;
    logic [2:0]   pc, bc;
    logic [7:0]   ex [N];
    logic [6:0]   ey [N];
    logic [2:0]   ec [N];
    logic [N-1:0] ea;
    logic         ba;
    logic [N*8-1:0] ex_flat;
    logic [N*7-1:0] ey_flat;
    logic [N*3-1:0] ec_flat;
    logic         busy, frame_done;
    logic [N-1:0] pe_hit, be_hit;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_pe = '0;
    logic [N-1:0] exp_be = '0;

    always #5 clk = ~clk;

    always_comb begin
        ex_flat = '0;
        ey_flat = '0;
        ec_flat = '0;
        for (int i = 0; i < N; i++) begin
            ex_flat[i*8 +: 8] = ex[i];
            ey_flat[i*7 +: 7] = ey[i];
            ec_flat[i*3 +: 3] = ec[i];
        end
    end

    sprite_draw_scheduler_if #(.X_W(8), .Y_W(7), .S_W(5), .C_W(3)) dif ();

    sprite_draw_scheduler #(.N_ENEMY(N), .X_W(8), .Y_W(7), .S_W(5), .C_W(3)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .frame_start_i   (frame_start),
        .player_x_i      (px),
        .player_y_i      (py),
        .player_w_i      (pw),
        .player_h_i      (ph),
        .player_colour_i (pc),
        .enemy_x_i       (ex_flat),
        .enemy_y_i       (ey_flat),
        .enemy_w_i       (ew),
        .enemy_h_i       (eh),
        .enemy_colour_i  (ec_flat),
        .enemy_active_i  (ea),
        .bullet_x_i      (bx),
        .bullet_y_i      (by),
        .bullet_w_i      (bw),
        .bullet_h_i      (bh),
        .bullet_colour_i (bc),
        .bullet_active_i (ba),
        .draw_if         (dif.master),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .pe_hit_o        (pe_hit),
        .be_hit_o        (be_hit),
        .hit_clear_i     (hit_clear)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rect_t draw_now();
        return rect_t'({dif.draw_x, dif.draw_y, dif.draw_w, dif.draw_h, dif.draw_colour});
    endfunction

    // Plain integer interval test: no widths, so no wrap-around.
    function automatic bit ovl(int ax, int ay, int aw, int ah, int bx_, int by_, int bw_, int bh_);
        if (aw == 0 || ah == 0 || bw_ == 0 || bh_ == 0) return 1'b0;
        return (ax < bx_ + bw_) && (bx_ < ax + aw) && (ay < by_ + bh_) && (by_ < ay + ah);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_draw"}, 64'(draw_now()), 64'(0));
        check({tag, "_start"}, 64'(dif.draw_start), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_fdone"}, 64'(frame_done), 64'(0));
        check({tag, "_pe"}, 64'(pe_hit), 64'(0));
        check({tag, "_be"}, 64'(be_hit), 64'(0));
    endtask

    task automatic rand_objs(input bit near);
        int xm, ym, sm;
        xm = near ? 40 : 255;
        ym = near ? 40 : 127;
        sm = near ? 12 : 31;
        px = 8'($urandom_range(0, xm)); py = 7'($urandom_range(0, ym));
        pw = 5'($urandom_range(0, sm)); ph = 5'($urandom_range(0, sm)); pc = 3'($urandom);
        bx = 8'($urandom_range(0, xm)); by = 7'($urandom_range(0, ym));
        bw = 5'($urandom_range(0, sm)); bh = 5'($urandom_range(0, sm)); bc = 3'($urandom);
        ew = 5'($urandom_range(0, sm)); eh = 5'($urandom_range(0, sm));
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'($urandom_range(0, xm));
            ey[i] = 7'($urandom_range(0, ym));
            ec[i] = 3'($urandom);
        end
        ea = N'($urandom);
        ba = 1'($urandom);
    endtask

    task automatic pulse_clear();
        hit_clear = 1'b1;
        @(posedge clk); #1;
        hit_clear = 1'b0;
        exp_pe = '0;
        exp_be = '0;
        check("clear_pe", 64'(pe_hit), 64'(0));
        check("clear_be", 64'(be_hit), 64'(0));
    endtask

    // One pass; called just after a clock edge with the block idle.
    task automatic run_frame(input int lat, input bit clr1, input bit disturb, input int abort_c);
        rect_t exp_q[$];
        rect_t got_q[$];
        logic [N-1:0] pe_x, be_x;
        int c, done_at, fd_c, fd_cnt, exp_len;
        bit aborted;
        exp_q.push_back(rect_t'({px, py, pw, ph, pc}));
        for (int i = 0; i < N; i++)
            if (ea[i]) exp_q.push_back(rect_t'({ex[i], ey[i], ew, eh, ec[i]}));
        if (ba) exp_q.push_back(rect_t'({bx, by, bw, bh, bc}));
        pe_x = clr1 ? '0 : exp_pe;
        be_x = clr1 ? '0 : exp_be;
        for (int i = 0; i < N; i++) begin
            if (ea[i] && ovl(px, py, pw, ph, ex[i], ey[i], ew, eh)) pe_x[i] = 1'b1;
            if (ea[i] && ba && ovl(bx, by, bw, bh, ex[i], ey[i], ew, eh)) be_x[i] = 1'b1;
        end
        exp_len = 2 + exp_q.size() * (lat + 1) + 1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        c = 1; done_at = -1; fd_c = -1; fd_cnt = 0; aborted = 1'b0;
        while (c < 400) begin
            hit_clear = clr1 && (c == 1);
            if (c == abort_c) begin
                resetn = 1'b0;
                dif.draw_done = 1'b0;
                #1;
                check_zero("abort");
                exp_pe = '0;
                exp_be = '0;
                @(posedge clk); #1;
                resetn = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (frame_done === 1'b1) fd_cnt++;
                    @(posedge clk); #1;
                end
                check("abort_no_frame_done", 64'(fd_cnt), 64'(0));
                check("abort_idle", 64'(busy), 64'(0));
                aborted = 1'b1;
                break;
            end
            if (c == 1) check("busy_high", 64'(busy), 64'(1));
            if (c == 2) begin
                check("pe_hit", 64'(pe_hit), 64'(pe_x));
                check("be_hit", 64'(be_hit), 64'(be_x));
            end
            if (dif.draw_start === 1'b1) begin
                got_q.push_back(draw_now());
                done_at = c + lat;
            end
            dif.draw_done = (c == done_at);
            if (c == done_at) check("draw_hold", 64'(draw_now()), 64'(got_q[$]));
            if (disturb && c == 4) begin
                frame_start = 1'b1;
                rand_objs(1'b1);
            end
            if (disturb && c == 5) frame_start = 1'b0;
            if (fd_c >= 0 && c == fd_c + 1) check("busy_low", 64'(busy), 64'(0));
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_c < 0) fd_c = c;
            end
            if (fd_c >= 0 && c == fd_c + 2) break;
            @(posedge clk); #1;
            c++;
        end
        dif.draw_done = 1'b0;
        hit_clear = 1'b0;
        frame_start = 1'b0;
        if (!aborted) begin
            check("frame_len", 64'(fd_c), 64'(exp_len));
            check("frame_done_count", 64'(fd_cnt), 64'(1));
            check("draw_count", 64'(got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("draw%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
            exp_pe = pe_x;
            exp_be = be_x;
        end
    endtask

    task automatic park_objs();
        px = 8'd100; py = 7'd100; pw = 5'd8; ph = 5'd8; pc = 3'd1;
        ew = 5'd4; eh = 5'd4;
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'(i * 50);
            ey[i] = 7'(i * 10);
            ec[i] = 3'(i + 2);
        end
        bx = 8'd150; by = 7'd60; bw = 5'd2; bh = 5'd2; bc = 3'd7;
        ea = '0; ba = 1'b0;
    endtask

    initial begin
        dif.draw_done = 1'b0;
        park_objs();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Enemies 1 and 3 alive, no bullet, drawer latency 3.
        ea = 4'b1010;
        run_frame(3, 1'b0, 1'b0, -1);

        // Player/enemy overlap, then touching edge, then far-right enemy (no wrap).
        park_objs();
        px = 8'd10; py = 7'd20; ex[0] = 8'd17; ey[0] = 7'd27; ea = 4'b0001;
        run_frame(2, 1'b0, 1'b0, -1);
        pulse_clear();
        ex[0] = 8'd18; ey[0] = 7'd20;
        run_frame(1, 1'b0, 1'b0, -1);
        ex[0] = 8'd250; ew = 5'd10; px = 8'd5;
        run_frame(1, 1'b0, 1'b0, -1);

        // Bullet vs enemy 2, active then inactive.
        park_objs();
        bx = 8'd40; by = 7'd40; bw = 5'd1; bh = 5'd3; ba = 1'b1;
        ex[2] = 8'd38; ey[2] = 7'd41; ea = 4'b0100;
        run_frame(2, 1'b0, 1'b0, -1);
        pulse_clear();
        ba = 1'b0;
        run_frame(2, 1'b0, 1'b0, -1);

        // Sticky flag cleared while idle, then clear racing a fresh set.
        park_objs();
        ex[1] = 8'd102; ey[1] = 7'd102; ea = 4'b0010;
        run_frame(1, 1'b0, 1'b0, -1);
        pulse_clear();
        run_frame(1, 1'b1, 1'b0, -1);

        // Re-trigger and input churn mid-pass.
        park_objs();
        ea = 4'b0110; ba = 1'b1;
        run_frame(3, 1'b0, 1'b1, -1);

        // Reset in WAIT, then a clean pass.
        park_objs();
        ea = 4'b1111; ba = 1'b1;
        run_frame(3, 1'b0, 1'b0, 3);
        run_frame(2, 1'b0, 1'b0, -1);

        for (int it = 0; it < 24; it++) begin
            rand_objs(it % 3 != 0);
            if (it % 5 == 0) begin
                ex[0] = 8'($urandom_range(240, 255));
                px = 8'($urandom_range(0, 8));
            end
            run_frame(int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0), 1'b0, -1);
            if ($urandom_range(0, 3) == 0) pulse_clear();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
